// File: rtl/ahb2_slave_pkg.sv
// Shared AHB-Lite transfer codes and byte-lane strobe helper for ahb2_slave.
package ahb2_slave_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HsizeByte = 3'b000,
    HsizeHalf = 3'b001,
    HsizeWord = 3'b010
  } hsize_e;

  // Byte-lane write strobe from transfer size and address low bits; sizes above
  // word collapse to a full-word write, misaligned low bits just pick lanes.
  function automatic logic [3:0] lane_strobe(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] strb;
    case (size)
      HsizeByte: strb = 4'b0001 << lane;
      HsizeHalf: strb = lane[1] ? 4'b1100 : 4'b0011;
      default:   strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahb2_slave_if.sv
// AHB-Lite slave-side bus bundle; HREADY is the bus-level ready from the interconnect.
interface ahb2_slave_if;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HREADYOUT, HRDATA
  );

  modport slave (
    input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HREADYOUT, HRDATA
  );
endinterface

// File: rtl/ahb2_slave_regfile.sv
// DEPTH x 32 word storage with byte write strobes, asynchronous read and a reset
// preset that replicates init_image into every byte.
module ahb2_slave_regfile #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [7:0]               init_image,
  input  logic                     we,
  input  logic [3:0]               strb,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);

  logic [31:0] mem_q [DEPTH];

  // Preset on reset, otherwise update only the strobed byte lanes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {4{init_image}};
      end
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Combinational read so a read right after a write sees the committed value.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/ahb2_slave.sv
// AHB-Lite slave around a small word register file. Zero wait states by default;
// define AHB2_SLAVE_WAIT_EN to insert exactly one wait state per accepted transfer.
module ahb2_slave
  import ahb2_slave_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic [7:0]   init_image,
  ahb2_slave_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic             valid_q, valid_d;
  logic             write_q, write_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       lane_q, lane_d;
  logic [2:0]       size_q, size_d;

  logic             ready_out;
  logic             accept;
  logic             wr_en;
  logic [3:0]       wr_strb;
  logic [31:0]      rd_word;

  // Address bits above the index field alias; HTRANS[0] (SEQ vs NONSEQ) is irrelevant here.
  logic unused_bits;
  assign unused_bits = ^{bus.HADDR[31:IDX_W+2], bus.HTRANS[0]};

`ifdef AHB2_SLAVE_WAIT_EN
  logic wait_q;

  // One-cycle wait flag raised by every accepted address phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) wait_q <= 1'b0;
    else          wait_q <= accept;
  end

  assign ready_out = ~wait_q;
`else
  assign ready_out = 1'b1;
`endif

  // Address phase is ignored while this slave is stalling the bus.
  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & ready_out;

  // Address-phase registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      size_q  <= 3'b000;
    end else begin
      valid_q <= valid_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
    end
  end

  // Capture a new transfer on accept; the data phase ends whenever the bus is ready.
  always_comb begin
    valid_d = valid_q;
    write_d = write_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    size_d  = size_q;
    if (bus.HREADY && ready_out) valid_d = accept;
    if (accept) begin
      write_d = bus.HWRITE;
      idx_d   = bus.HADDR[IDX_W+1:2];
      lane_d  = bus.HADDR[1:0];
      size_d  = bus.HSIZE;
    end
  end

  // Data-phase outputs: write commit on the completing edge, read data gated to read phases.
  always_comb begin
    wr_en         = valid_q & write_q & ready_out;
    wr_strb       = lane_strobe(size_q, lane_q);
    bus.HREADYOUT = ready_out;
    bus.HRDATA    = (valid_q && !write_q && ready_out) ? rd_word : 32'h0;
  end

  ahb2_slave_regfile #(
    .DEPTH (DEPTH)
  ) u_regfile (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .init_image (init_image),
    .we         (wr_en),
    .strb       (wr_strb),
    .waddr      (idx_q),
    .wdata      (bus.HWDATA),
    .raddr      (idx_q),
    .rdata      (rd_word)
  );

endmodule

// File: tb/tb_ahb2_slave.sv
// Directed self-checking bench for ahb2_slave (DEPTH=16); handles either wait-state build.
module tb_ahb2_slave;

`ifdef AHB2_SLAVE_WAIT_EN
  localparam int ExpWaits = 1;
`else
  localparam int ExpWaits = 0;
`endif

  logic       HCLK;
  logic       HRESETn;
  logic [7:0] init_image;
  logic       hready_tb;

  int tests_run;
  int fails;

  ahb2_slave_if bus ();

  // Single-slave bus: HREADY follows this slave unless the bench forces it low.
  assign bus.HREADY = hready_tb & bus.HREADYOUT;

  ahb2_slave #(
    .DEPTH (16)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .init_image (init_image),
    .bus        (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'h0;
    bus.HSIZE  = 3'b010;
    hready_tb  = 1'b1;
  endtask

  // Caller is at a negedge; drives the address phase now so transfers pipeline back to back.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output int waits);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = wr;
    bus.HADDR  = addr;
    bus.HSIZE  = size;
    hready_tb  = 1'b1;
    @(posedge HCLK);
    #1;
    bus_idle();
    bus.HWDATA = wr ? wdata : 32'h5A5A_0000;
    waits = 0;
    @(negedge HCLK);
    while (!bus.HREADYOUT && waits < 8) begin
      waits++;
      @(negedge HCLK);
    end
    rdata = bus.HRDATA;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    logic [31:0] rdata;
    int          waits;
    do_xfer(1'b1, addr, size, data, rdata, waits);
    check("wr_hrdata_zero", rdata, 32'h0);
    check("wr_waits", waits, ExpWaits);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rdata;
    int          waits;
    do_xfer(1'b0, addr, 3'b010, 32'h0, rdata, waits);
    check(tag, rdata, exp);
    check("rd_waits", waits, ExpWaits);
  endtask

  // A write-shaped address phase that must not be accepted.
  task automatic no_accept(input string tag, input logic sel, input logic [1:0] trans,
                           input logic hrdy, input logic [31:0] addr);
    @(negedge HCLK);
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HWRITE = 1'b1;
    bus.HADDR  = addr;
    bus.HSIZE  = 3'b010;
    hready_tb  = hrdy;
    @(posedge HCLK);
    #1;
    bus_idle();
    bus.HWDATA = 32'hDEAD_BEEF;
    @(negedge HCLK);
    check({tag, "_hreadyout"}, {31'h0, bus.HREADYOUT}, 32'h1);
    check({tag, "_hrdata"}, bus.HRDATA, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    tests_run  = 0;
    fails      = 0;
    HRESETn    = 1'b0;
    init_image = 8'h0F;
    bus.HWDATA = 32'h0;
    bus_idle();
    repeat (3) @(negedge HCLK);
    check("rst_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
    check("rst_hrdata", bus.HRDATA, 32'h0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    rd("rd_preset_w0", 32'h1, 32'h0F0F_0F0F);

    // Write then back-to-back read of the same word, plus an untouched word.
    wr(32'h1, 3'b010, 32'hFFFF_FFFF);
    rd("rd_w0_after_wr", 32'h0, 32'hFFFF_FFFF);
    rd("rd_w4_preset", 32'h10, 32'h0F0F_0F0F);

    no_accept("unsel", 1'b0, 2'b10, 1'b1, 32'h8);
    rd("rd_w2_unsel", 32'h8, 32'h0F0F_0F0F);

    // Byte and halfword lane updates.
    wr(32'h5, 3'b000, 32'hAAAA_AAAA);
    wr(32'hA, 3'b001, 32'h1234_1234);
    rd("rd_w1_byte", 32'h4, 32'h0F0F_AA0F);
    rd("rd_w2_half", 32'h8, 32'h1234_0F0F);

    // Selected writes that are not real transfers.
    no_accept("hready_lo", 1'b1, 2'b10, 1'b0, 32'hC);
    no_accept("idle", 1'b1, 2'b00, 1'b1, 32'hC);
    no_accept("busy", 1'b1, 2'b01, 1'b1, 32'hC);
    @(negedge HCLK);
    rd("rd_w3_unchanged", 32'hC, 32'h0F0F_0F0F);

    // Aliasing above the index field, misaligned half, oversize treated as word.
    wr(32'h40, 3'b010, 32'h1122_3344);
    rd("rd_w0_alias", 32'h0, 32'h1122_3344);
    wr(32'h3, 3'b001, 32'hBEEF_CAFE);
    rd("rd_w0_unaligned_half", 32'h0, 32'hBEEF_3344);
    wr(32'h14, 3'b011, 32'hCAFE_F00D);
    rd("rd_w5_size3", 32'h14, 32'hCAFE_F00D);
    wr(32'h1C, 3'b000, 32'h5555_5555);
    rd("rd_w7_byte0", 32'h1C, 32'h0F0F_0F55);
    wr(32'hF, 3'b000, 32'h7777_7777);
    rd("rd_w3_byte3", 32'hC, 32'h770F_0F0F);

    // Reset in the middle of a write data phase restores the (new) preset.
    init_image = 8'h3C;
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = 1'b1;
    bus.HADDR  = 32'h18;
    bus.HSIZE  = 3'b010;
    @(posedge HCLK);
    #1;
    bus_idle();
    bus.HWDATA = 32'h9999_9999;
    HRESETn    = 1'b0;
    @(negedge HCLK);
    check("midrst_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
    check("midrst_hrdata", bus.HRDATA, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    rd("rd_w6_after_rst", 32'h18, 32'h3C3C_3C3C);
    rd("rd_w1_after_rst", 32'h4, 32'h3C3C_3C3C);

    repeat (2) @(negedge HCLK);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
